// File: rtl/mister_loader_pkg.sv
// Shared types and constants for the MiSTer dictionary / Bloom-filter loader.
package mister_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_DICT,
        LD_BLOOM,
        BLOOM_SER,
        FINISH
    } loader_state_t;

    localparam int RECORD_BYTES = 6;
    localparam int DICT_DATA_W  = 41;
    localparam int ASM_W        = 8 * RECORD_BYTES;
    localparam int LOAD_ADDR_W  = 16;

    localparam logic [7:0] DICT_INDEX_DEFAULT  = 8'h02;
    localparam logic [7:0] BLOOM_INDEX_DEFAULT = 8'h03;

endpackage

// File: rtl/bloom_byte_serializer.sv
// Turns one latched Bloom byte into eight consecutive single-bit writes, LSB first.
module bloom_byte_serializer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic [ADDR_W-4:0] base_addr,
    output logic              bit_en,
    output logic [ADDR_W-1:0] bit_addr,
    output logic              bit_val,
    output logic              busy,
    output logic              last
);

    logic [7:0]        byte_q;
    logic [ADDR_W-4:0] base_q;
    logic [2:0]        idx_q;
    logic              busy_q;

    // Latch the byte on start, then step the bit index once per cycle until bit 7 is out.
    always_ff @(posedge clk_sys or posedge reset) begin
        // NOTE: non-blocking assignments keep every register update in this block
        // referring to pre-edge values, so ordering of statements cannot create races.
        if (reset) begin
            byte_q <= '0;
            base_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            byte_q <= byte_in;
            base_q <= base_addr;
            idx_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Outputs are quiet (all zero) whenever no byte is being serialized.
    assign bit_en   = busy_q;
    assign bit_val  = busy_q & byte_q[idx_q];
    assign bit_addr = busy_q ? {base_q, idx_q} : '0;
    assign busy     = busy_q;
    assign last     = busy_q && (idx_q == 3'd7);

endmodule

// File: rtl/mister_dict_loader.sv
// Converts the HPS ioctl byte stream into dictionary-record and Bloom-bit load strobes.
module mister_dict_loader
    import mister_loader_pkg::*;
#(
    parameter logic [7:0] DICT_INDEX  = DICT_INDEX_DEFAULT,
    parameter logic [7:0] BLOOM_INDEX = BLOOM_INDEX_DEFAULT,
    parameter int         DICT_DEPTH  = 65536,
    parameter int         BLOOM_BITS  = 65536
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic [7:0]             ioctl_index,
    output logic                   ioctl_wait,
    output logic                   dict_load_en,
    output logic [LOAD_ADDR_W-1:0] dict_load_addr,
    output logic [DICT_DATA_W-1:0] dict_load_data,
    output logic                   bloom_load_en,
    output logic [LOAD_ADDR_W-1:0] bloom_load_addr,
    output logic                   bloom_load_bit,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_error,
    output logic [15:0]            entry_count
);

    localparam logic [16:0] DICT_LIMIT       = 17'(DICT_DEPTH);
    localparam logic [24:0] BLOOM_BYTE_LIMIT = 25'(BLOOM_BITS / 8);
    localparam logic [2:0]  LAST_BYTE        = 3'(RECORD_BYTES - 1);

    loader_state_t state_q, state_d;

    logic             dl_q;
    logic [24:0]      exp_addr_q;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [16:0]      rec_num_q;
    logic [ASM_W-1:0] asm_q, asm_word;

    logic dl_rise, addr_ok, rec_last;
    logic dict_take, bloom_take, err_set, start_dict, start_bloom;
    logic ser_last;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign addr_ok  = (ioctl_addr == exp_addr_q);
    assign rec_last = (byte_cnt_q == LAST_BYTE);

    // State register plus the download-window edge detector.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            // Reset to 1 so a download still open across reset is not seen as a new rise.
            dl_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
        end
    end

    // Next-state logic and per-cycle accept/reject decisions for incoming bytes.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        dict_take   = 1'b0;
        bloom_take  = 1'b0;
        err_set     = 1'b0;
        start_dict  = 1'b0;
        start_bloom = 1'b0;
        asm_word    = asm_q;
        asm_word[{byte_cnt_q, 3'b000} +: 8] = ioctl_dout;

        unique case (state_q)
            IDLE: begin
                if (dl_rise && ioctl_index == DICT_INDEX) begin
                    state_d    = LD_DICT;
                    start_dict = 1'b1;
                end else if (dl_rise && ioctl_index == BLOOM_INDEX) begin
                    state_d     = LD_BLOOM;
                    start_bloom = 1'b1;
                end
            end
            LD_DICT: begin
                if (ioctl_wr) begin
                    if (addr_ok && rec_num_q < DICT_LIMIT) dict_take = 1'b1;
                    else                                   err_set   = 1'b1;
                end
                if (dict_take && rec_last && asm_word[ASM_W-1:DICT_DATA_W] != '0) begin
                    err_set = 1'b1;
                end
                if (!ioctl_download) begin
                    state_d = FINISH;
                    if (byte_cnt_d != 3'd0) err_set = 1'b1;
                end
            end
            LD_BLOOM: begin
                if (ioctl_wr) begin
                    if (addr_ok && exp_addr_q < BLOOM_BYTE_LIMIT) begin
                        bloom_take = 1'b1;
                        state_d    = BLOOM_SER;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                if (!ioctl_download && !bloom_take) state_d = FINISH;
            end
            BLOOM_SER: begin
                if (ioctl_wr) err_set = 1'b1;
                if (ser_last) state_d = ioctl_download ? LD_BLOOM : FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte position within the record after this cycle's byte (if any) is absorbed.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (dict_take) byte_cnt_d = rec_last ? 3'd0 : byte_cnt_q + 3'd1;
    end

    // Record assembly, address tracking, dictionary strobe and sticky status.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            exp_addr_q     <= '0;
            byte_cnt_q     <= '0;
            rec_num_q      <= '0;
            asm_q          <= '0;
            dict_load_en   <= 1'b0;
            dict_load_addr <= '0;
            dict_load_data <= '0;
            load_error     <= 1'b0;
            entry_count    <= '0;
        end else begin
            dict_load_en <= 1'b0;
            if (err_set) load_error <= 1'b1;
            if (start_dict || start_bloom) begin
                load_error <= 1'b0;
                exp_addr_q <= '0;
                byte_cnt_q <= '0;
                rec_num_q  <= '0;
                asm_q      <= '0;
            end
            if (start_dict) entry_count <= '0;
            if (dict_take) begin
                exp_addr_q <= exp_addr_q + 25'd1;
                byte_cnt_q <= byte_cnt_d;
                asm_q      <= asm_word;
                if (rec_last) begin
                    dict_load_en   <= 1'b1;
                    dict_load_addr <= rec_num_q[LOAD_ADDR_W-1:0];
                    dict_load_data <= asm_word[DICT_DATA_W-1:0];
                    rec_num_q      <= rec_num_q + 17'd1;
                    entry_count    <= entry_count + 16'd1;
                end
            end
            if (bloom_take) exp_addr_q <= exp_addr_q + 25'd1;
        end
    end

    bloom_byte_serializer #(
        .ADDR_W (LOAD_ADDR_W)
    ) u_ser (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (bloom_take),
        .byte_in   (ioctl_dout),
        .base_addr (ioctl_addr[LOAD_ADDR_W-4:0]),
        .bit_en    (bloom_load_en),
        .bit_addr  (bloom_load_addr),
        .bit_val   (bloom_load_bit),
        .busy      (ioctl_wait),
        .last      (ser_last)
    );

    assign load_busy = (state_q == LD_DICT) || (state_q == LD_BLOOM) || (state_q == BLOOM_SER);
    assign load_done = (state_q == FINISH);

endmodule

// File: tb/tb_mister_dict_loader.sv
// Directed self-checking bench for mister_dict_loader.
module tb_mister_dict_loader;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        dict_load_en;
    logic [15:0] dict_load_addr;
    logic [40:0] dict_load_data;
    logic        bloom_load_en;
    logic [15:0] bloom_load_addr;
    logic        bloom_load_bit;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] entry_count;

    int checks = 0;
    int errors = 0;

    // Event logs filled by the monitor on the falling edge.
    int          dict_cnt    = 0;
    int          bloom_cnt   = 0;
    int          wait_cycles = 0;
    int          done_cnt    = 0;
    int          busy_cnt    = 0;
    logic [15:0] dict_addr_log [32];
    logic [40:0] dict_data_log [32];
    bit          bloom_mem     [256];

    int d0, b0, w0, n0, u0;

    mister_dict_loader dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_index     (ioctl_index),
        .ioctl_wait      (ioctl_wait),
        .dict_load_en    (dict_load_en),
        .dict_load_addr  (dict_load_addr),
        .dict_load_data  (dict_load_data),
        .bloom_load_en   (bloom_load_en),
        .bloom_load_addr (bloom_load_addr),
        .bloom_load_bit  (bloom_load_bit),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_error      (load_error),
        .entry_count     (entry_count)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Record strobes and status away from the active edge.
    always @(negedge clk_sys) begin
        if (dict_load_en) begin
            if (dict_cnt < 32) begin
                dict_addr_log[dict_cnt] = dict_load_addr;
                dict_data_log[dict_cnt] = dict_load_data;
            end
            dict_cnt = dict_cnt + 1;
        end
        if (bloom_load_en) begin
            bloom_mem[bloom_load_addr[7:0]] = bloom_load_bit;
            bloom_cnt = bloom_cnt + 1;
        end
        if (ioctl_wait) wait_cycles = wait_cycles + 1;
        if (load_done)  done_cnt    = done_cnt + 1;
        if (load_busy)  busy_cnt    = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ioctl_wait && n < 40) begin
            tick();
            n = n + 1;
        end
        if (ioctl_wait) begin
            checks = checks + 1;
            errors = errors + 1;
            $error("FAIL wait_timeout: ioctl_wait still high after %0d cycles", n);
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        wait_idle();
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [7:0] bloom_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = bloom_mem[base + i];
        return b;
    endfunction

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        #1;
        check("reset_ctl", 64'({ioctl_wait, dict_load_en, bloom_load_en, bloom_load_bit, load_busy,
                                load_done, load_error, entry_count, dict_load_addr, bloom_load_addr}), '0);
        check("reset_data", 64'(dict_load_data), '0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: two dictionary records
        d0 = dict_cnt; n0 = done_cnt;
        start_dl(8'h02);
        check("t1_busy", 64'(load_busy), 64'(1));
        send_byte(0, 8'h01); send_byte(1, 8'h00); send_byte(2, 8'h00);
        send_byte(3, 8'h00); send_byte(4, 8'h00); send_byte(5, 8'h00);
        send_byte(6, 8'hFF); send_byte(7, 8'hFF); send_byte(8, 8'hFF);
        send_byte(9, 8'hFF); send_byte(10, 8'hFF); send_byte(11, 8'h01);
        end_dl();
        check("t1_nrec", 64'(dict_cnt - d0), 64'(2));
        check("t1_addr0", 64'(dict_addr_log[d0]), 64'(0));
        check("t1_data0", 64'(dict_data_log[d0]), 64'(41'h1));
        check("t1_addr1", 64'(dict_addr_log[d0 + 1]), 64'(1));
        check("t1_data1", 64'(dict_data_log[d0 + 1]), 64'(41'h1_FFFF_FFFFFF));
        check("t1_count", 64'(entry_count), 64'(2));
        check("t1_done", 64'(done_cnt - n0), 64'(1));
        check("t1_error", 64'(load_error), 64'(0));
        check("t1_idle", 64'(load_busy), 64'(0));

        // 2: Bloom byte A5 landing at byte address 3
        b0 = bloom_cnt; n0 = done_cnt;
        start_dl(8'h03);
        send_byte(0, 8'h00); send_byte(1, 8'h00); send_byte(2, 8'h00);
        wait_idle();
        w0 = wait_cycles;
        send_byte(3, 8'hA5);
        check("t2_wait_now", 64'(ioctl_wait), 64'(1));
        wait_idle();
        check("t2_wait_len", 64'(wait_cycles - w0), 64'(8));
        check("t2_nbits", 64'(bloom_cnt - b0), 64'(32));
        check("t2_no_done", 64'(done_cnt - n0), 64'(0));
        end_dl();
        check("t2_bits", 64'(bloom_byte(24)), 64'(8'hA5));
        check("t2_done", 64'(done_cnt - n0), 64'(1));
        check("t2_error", 64'(load_error), 64'(0));

        // 3: dictionary download cut after 7 bytes
        d0 = dict_cnt; n0 = done_cnt;
        start_dl(8'h02);
        send_byte(0, 8'h11); send_byte(1, 8'h22); send_byte(2, 8'h33);
        send_byte(3, 8'h44); send_byte(4, 8'h55); send_byte(5, 8'h00);
        send_byte(6, 8'h77);
        end_dl();
        check("t3_nrec", 64'(dict_cnt - d0), 64'(1));
        check("t3_data", 64'(dict_data_log[d0]), 64'(41'h55_4433_2211));
        check("t3_error", 64'(load_error), 64'(1));
        check("t3_done", 64'(done_cnt - n0), 64'(1));
        check("t3_count", 64'(entry_count), 64'(1));

        // 4: write while serializing is dropped
        b0 = bloom_cnt; n0 = done_cnt;
        start_dl(8'h03);
        check("t4_err_clr", 64'(load_error), 64'(0));
        send_byte(0, 8'h3C);
        ioctl_addr = 25'd1;
        ioctl_dout = 8'hFF;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        wait_idle();
        check("t4_error", 64'(load_error), 64'(1));
        check("t4_nbits", 64'(bloom_cnt - b0), 64'(8));
        check("t4_bits0", 64'(bloom_byte(0)), 64'(8'h3C));
        check("t4_bits1", 64'(bloom_byte(8)), 64'(8'h00));
        end_dl();
        check("t4_done", 64'(done_cnt - n0), 64'(1));

        // 5: unknown index ignored, then a valid dict download clears the error
        d0 = dict_cnt; b0 = bloom_cnt; n0 = done_cnt; u0 = busy_cnt;
        start_dl(8'h07);
        for (int i = 0; i < 6; i++) send_byte(25'(i), 8'h5A);
        end_dl();
        check("t5_nrec", 64'(dict_cnt - d0), 64'(0));
        check("t5_nbits", 64'(bloom_cnt - b0), 64'(0));
        check("t5_busy", 64'(busy_cnt - u0), 64'(0));
        check("t5_done", 64'(done_cnt - n0), 64'(0));
        check("t5_err_kept", 64'(load_error), 64'(1));
        start_dl(8'h02);
        check("t5_err_clr", 64'(load_error), 64'(0));
        send_byte(0, 8'h02);
        for (int i = 1; i < 6; i++) send_byte(25'(i), 8'h00);
        end_dl();
        check("t5_data", 64'(dict_data_log[d0]), 64'(41'h2));
        check("t5_error", 64'(load_error), 64'(0));

        // 6: reset mid-download
        start_dl(8'h02);
        send_byte(0, 8'hAA); send_byte(1, 8'hBB); send_byte(2, 8'hCC);
        reset = 1'b1;
        #1;
        check("t6_rst_ctl", 64'({ioctl_wait, dict_load_en, bloom_load_en, bloom_load_bit, load_busy,
                                 load_done, load_error, entry_count, dict_load_addr, bloom_load_addr}), '0);
        check("t6_rst_data", 64'(dict_load_data), '0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        d0 = dict_cnt;
        send_byte(3, 8'hDD);
        check("t6_ignored_busy", 64'(load_busy), 64'(0));
        end_dl();
        check("t6_ignored_rec", 64'(dict_cnt - d0), 64'(0));
        start_dl(8'h02);
        send_byte(0, 8'h10); send_byte(1, 8'h20); send_byte(2, 8'h30);
        send_byte(3, 8'h40); send_byte(4, 8'h50); send_byte(5, 8'h00);
        end_dl();
        check("t6_addr", 64'(dict_addr_log[d0]), 64'(0));
        check("t6_data", 64'(dict_data_log[d0]), 64'(41'h50_4030_2010));
        check("t6_count", 64'(entry_count), 64'(1));

        // 7: download falls on the same cycle as the last Bloom byte
        b0 = bloom_cnt; n0 = done_cnt;
        start_dl(8'h03);
        wait_idle();
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'h81;
        ioctl_wr       = 1'b1;
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        wait_idle();
        repeat (3) tick();
        check("t7_nbits", 64'(bloom_cnt - b0), 64'(8));
        check("t7_bits", 64'(bloom_byte(0)), 64'(8'h81));
        check("t7_done", 64'(done_cnt - n0), 64'(1));

        // 8: out-of-sequence address is dropped and flagged
        d0 = dict_cnt;
        start_dl(8'h02);
        send_byte(0, 8'h01);
        send_byte(5, 8'hEE);
        check("t8_error", 64'(load_error), 64'(1));
        send_byte(1, 8'h02); send_byte(2, 8'h03); send_byte(3, 8'h04);
        send_byte(4, 8'h05); send_byte(5, 8'h00);
        end_dl();
        check("t8_nrec", 64'(dict_cnt - d0), 64'(1));
        check("t8_data", 64'(dict_data_log[d0]), 64'(41'h05_0403_0201));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
